// File: rtl/and_mux_bist_pkg.sv
// Shared types and golden model for the AND/mux datapath self-test.
package and_mux_bist_pkg;

  localparam int VEC_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } bist_state_e;

  // vec = {s,b,a}; datapath computes y = s ? b : (a & b)
  function automatic logic golden_y(input logic [VEC_W-1:0] vec);
    return vec[2] ? vec[1] : (vec[1] & vec[0]);
  endfunction

endpackage

// File: rtl/bist_sat_counter.sv
// Saturating up-counter with synchronous clear.
module bist_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                        count_d = '0;
    else if (inc && count_q != '1)  count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;

  assign count = count_q;

endmodule

// File: rtl/and_mux_bist_ctrl.sv
// BIST sequencer: sweeps all {s,b,a} vectors into the AND/mux datapath,
// compares the settled output with the golden model and logs mismatches.
module and_mux_bist_ctrl
  import and_mux_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_s,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LD = SC_W'(SETTLE_CYCLES);
  localparam logic [PC_W-1:0] PASS_LAST = PC_W'(PASSES - 1);

  bist_state_e      state_q;
  logic [VEC_W-1:0] vec_q, dut_q, ffv_q;
  logic [PC_W-1:0]  pass_q;
  logic [SC_W-1:0]  settle_q;
  logic             busy_q, done_q, ffvalid_q;

  logic accept, mismatch, err_inc;

  // abort beats start when both arrive in an idle state
  assign accept   = (state_q == ST_IDLE || state_q == ST_DONE) && start && !abort;
  assign mismatch = dut_y != golden_y(vec_q);
  assign err_inc  = (state_q == ST_CHECK) && mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      dut_q     <= '0;
      ffv_q     <= '0;
      pass_q    <= '0;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ffvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            vec_q     <= '0;
            pass_q    <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_APPLY;
          end else if (abort) begin
            state_q <= ST_IDLE;
          end
        end
        ST_APPLY: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            dut_q   <= '0;
          end else begin
            dut_q    <= vec_q;
            settle_q <= SETTLE_LD;
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            dut_q   <= '0;
          end else begin
            settle_q <= settle_q - 1'b1;
            if (settle_q == SC_W'(1)) state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // first-fail capture happens even if this cycle is aborted
          if (mismatch && !ffvalid_q) begin
            ffv_q     <= vec_q;
            ffvalid_q <= 1'b1;
          end
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            dut_q   <= '0;
          end else if (vec_q != 3'd7) begin
            vec_q   <= vec_q + 3'd1;
            state_q <= ST_APPLY;
          end else if (pass_q != PASS_LAST) begin
            vec_q   <= '0;
            pass_q  <= pass_q + 1'b1;
            state_q <= ST_APPLY;
          end else begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dut_q   <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  bist_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (err_inc),
    .count (err_count)
  );

  assign dut_a            = dut_q[0];
  assign dut_b            = dut_q[1];
  assign dut_s            = dut_q[2];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = done_q && (err_count == '0);
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_and_mux_bist_ctrl.sv
// Directed bench: three controller instances (defaults, ERR_W=2, PASSES=2)
// each driving a behavioural datapath with selectable fault mode.
module tb_and_mux_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // mode: 0 ideal, 1 stuck-at-0, 2 inverted, 3 stuck-at-1
  int mode0 = 0, mode1 = 0, mode2 = 0;
  logic start0 = 0, start1 = 0, start2 = 0;
  logic abort0 = 0, abort1 = 0, abort2 = 0;

  logic a0, b0, s0, y0, busy0, done0, pass0, ffok0;
  logic a1, b1, s1, y1, busy1, done1, pass1, ffok1;
  logic a2, b2, s2, y2, busy2, done2, pass2, ffok2;
  logic [7:0] err0, err2;
  logic [1:0] err1;
  logic [2:0] ffv0, ffv1, ffv2;

  function automatic logic ymod(input int m, input logic a, input logic b, input logic s);
    logic g;
    g = s ? b : (a & b);
    case (m)
      1: return 1'b0;
      2: return ~g;
      3: return 1'b1;
      default: return g;
    endcase
  endfunction

  assign y0 = ymod(mode0, a0, b0, s0);
  assign y1 = ymod(mode1, a1, b1, s1);
  assign y2 = ymod(mode2, a2, b2, s2);

  and_mux_bist_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .dut_a(a0), .dut_b(b0), .dut_s(s0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_valid(ffok0));

  and_mux_bist_ctrl #(.ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .dut_a(a1), .dut_b(b1), .dut_s(s1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffok1));

  and_mux_bist_ctrl #(.PASSES(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .dut_a(a2), .dut_b(b2), .dut_s(s2), .dut_y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail_vec(ffv2), .first_fail_valid(ffok2));

  function automatic logic done_of(input int sel);
    case (sel)
      1: return done1;
      2: return done2;
      default: return done0;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      1: start1 = v;
      2: start2 = v;
      default: start0 = v;
    endcase
  endtask

  // Called #1 after a rising edge; returns cycles from start cycle to done, -1 on timeout.
  task automatic run_until_done(input int sel, input int limit, output int n);
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    n = 1;
    while (!done_of(sel) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_of(sel)) n = -1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
    checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass0); end
    checks++; if (err0 !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err0); end
    checks++; if ({ffok0, ffv0} !== 4'b0) begin errors++; $display("FAIL reset_ff: got %b expected 0000", {ffok0, ffv0}); end
    checks++; if ({s0, b0, a0} !== 3'b000) begin errors++; $display("FAIL reset_dut: got %b expected 000", {s0, b0, a0}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ideal;
    int n;
    mode0 = 0;
    run_until_done(0, 200, n);
    checks++; if (n !== 33) begin errors++; $display("FAIL ideal_latency: got %0d expected 33", n); end
    checks++; if (err0 !== 8'd0) begin errors++; $display("FAIL ideal_err: got %0d expected 0", err0); end
    checks++; if (pass0 !== 1'b1) begin errors++; $display("FAIL ideal_pass: got %b expected 1", pass0); end
    checks++; if (ffok0 !== 1'b0) begin errors++; $display("FAIL ideal_ffvalid: got %b expected 0", ffok0); end
    checks++; if ({busy0, s0, b0, a0} !== 4'b0) begin errors++; $display("FAIL ideal_idle_outs: got %b expected 0000", {busy0, s0, b0, a0}); end
  endtask

  task automatic test_stuck0;
    int n;
    mode0 = 1;
    run_until_done(0, 200, n);
    checks++; if (n !== 33) begin errors++; $display("FAIL stuck0_latency: got %0d expected 33", n); end
    checks++; if (err0 !== 8'd3) begin errors++; $display("FAIL stuck0_err: got %0d expected 3", err0); end
    checks++; if (ffv0 !== 3'b011 || ffok0 !== 1'b1) begin errors++; $display("FAIL stuck0_first: got %b/%b expected 011/1", ffv0, ffok0); end
    checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL stuck0_pass: got %b expected 0", pass0); end
  endtask

  task automatic test_saturate;
    int n;
    mode1 = 2;
    run_until_done(1, 200, n);
    checks++; if (n !== 33) begin errors++; $display("FAIL sat_latency: got %0d expected 33", n); end
    checks++; if (err1 !== 2'd3) begin errors++; $display("FAIL sat_err: got %0d expected 3", err1); end
    checks++; if (ffv1 !== 3'b000 || ffok1 !== 1'b1) begin errors++; $display("FAIL sat_first: got %b/%b expected 000/1", ffv1, ffok1); end
    checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL sat_pass: got %b expected 0", pass1); end
  endtask

  task automatic test_passes;
    int n;
    mode2 = 3;
    run_until_done(2, 300, n);
    checks++; if (n !== 65) begin errors++; $display("FAIL p2_latency: got %0d expected 65", n); end
    checks++; if (err2 !== 8'd10) begin errors++; $display("FAIL p2_err: got %0d expected 10", err2); end
    checks++; if (ffv2 !== 3'b000 || ffok2 !== 1'b1) begin errors++; $display("FAIL p2_first: got %b/%b expected 000/1", ffv2, ffok2); end
  endtask

  task automatic test_abort;
    int n;
    mode0 = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    // cycle start+10: SETTLE of vector 2
    checks++; if ({busy0, done0, s0, b0, a0} !== 5'b10010) begin errors++; $display("FAIL abort_pre: got %b expected 10010", {busy0, done0, s0, b0, a0}); end
    abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    checks++; if ({busy0, done0, s0, b0, a0} !== 5'b00000) begin errors++; $display("FAIL abort_post: got %b expected 00000", {busy0, done0, s0, b0, a0}); end
    checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL abort_pass: got %b expected 0", pass0); end
    start0 = 1'b1;
    abort0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    abort0 = 1'b0;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_wins_idle: got busy %b expected 0", busy0); end
    run_until_done(0, 200, n);
    checks++; if (n !== 33) begin errors++; $display("FAIL abort_rerun_latency: got %0d expected 33", n); end
    checks++; if (err0 !== 8'd0 || pass0 !== 1'b1) begin errors++; $display("FAIL abort_rerun_result: got err %0d pass %b expected 0/1", err0, pass0); end
  endtask

  task automatic test_back_to_back;
    int n;
    mode0 = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 1;
    while (!done0 && n < 200) begin
      start0 = (n == 5);
      @(posedge clk); #1;
      n++;
    end
    start0 = 1'b0;
    if (!done0) n = -1;
    checks++; if (n !== 33) begin errors++; $display("FAIL busy_start_latency: got %0d expected 33", n); end
  endtask

  task automatic test_reset_mid;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    // in SETTLE of vector 0
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b expected 1", busy0); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy0, done0, pass0, s0, b0, a0} !== 6'b0) begin errors++; $display("FAIL midrst_outs: got %b expected 000000", {busy0, done0, pass0, s0, b0, a0}); end
    checks++; if ({err0, ffok0, ffv0} !== 12'd0) begin errors++; $display("FAIL midrst_status: got %h expected 000", {err0, ffok0, ffv0}); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL midrst_stays_idle: got busy %b done %b expected 0/0", busy0, done0); end
  endtask

  initial begin
    test_reset;
    test_ideal;
    test_stuck0;
    test_saturate;
    test_passes;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/and_mux_bist_ctrl.md
Name: and_mux_bist_ctrl

Overview:
Built-in self-test sequencer for the placed AND/mux datapath, which computes y = s ? b : (a & b).
- Drives the datapath's a/b/s inputs through all 8 input vectors, waits a settle interval, samples y and compares it against an internal golden model.
- Counts mismatches and records the first failing vector.
- Sits beside the datapath on the same clock; used to detect tampered or misrouted placements.

Parameters:
- SETTLE_CYCLES, 2, wait cycles between driving a vector and sampling y; legal range ≥1.
- PASSES, 1, number of full 8-vector sweeps per run; legal range ≥1.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  cancel the run; honoured in any non-IDLE state.
- dut_a  out  1  drive to datapath input a.
- dut_b  out  1  drive to datapath input b.
- dut_s  out  1  drive to datapath select s.
- dut_y  in  1  datapath output; synchronous to clk.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next accepted start.
- pass  out  1  equals done && (err_count == 0).
- err_count  out  ERR_W  saturating mismatch count.
- first_fail_vec  out  3  failing vector {s,b,a} of the first mismatch.
- first_fail_valid  out  1  first_fail_vec holds a captured value.

Behaviour:
- Reset (async assert, sync deassert handled upstream): all outputs 0; FSM enters IDLE; all counters 0.
- Vector encoding: vec = {s,b,a}, applied in order 0..7 and repeated PASSES times.
- Golden model: exp = vec[2] ? vec[1] : (vec[1] & vec[0]). Expected 1 only for vectors 3, 6 and 7.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
  - IDLE: on start, clear err_count, first_fail_*, done, vec counter and pass counter; go to APPLY.
  - APPLY (1 cycle): register dut_{s,b,a} = vec; load settle counter with SETTLE_CYCLES; go to SETTLE.
  - SETTLE: decrement the counter; leave for CHECK when it reaches 0. Duration is exactly SETTLE_CYCLES cycles.
  - CHECK (1 cycle):
    - Compare dut_y with exp.
    - On mismatch: err_count increments and saturates at 2^ERR_W−1.
    - If first_fail_valid is 0, capture vec into first_fail_vec and set first_fail_valid.
    - If vec < 7: vec++ and go to APPLY.
    - If vec == 7 and pass index < PASSES−1: vec wraps to 0, pass++, go to APPLY.
    - Otherwise go to DONE.
  - DONE: done=1, busy=0, dut_* = 0. On start, clear state as in IDLE and go to APPLY; otherwise stay.
- busy is 1 in APPLY, SETTLE and CHECK, and is registered.
- dut_* hold their value from APPLY through CHECK.
- Latency: (SETTLE_CYCLES+2) cycles per vector. done rises 1 + 8·PASSES·(SETTLE_CYCLES+2) cycles after the start cycle. With defaults this is cycle 33.
- start while busy is ignored.
- start and abort together in IDLE: abort wins and the run does not start.
- abort in APPLY, SETTLE or CHECK: next state IDLE; busy=0, dut_*=0, done stays 0. err_count and first_fail_* retain their values for debug.
- A mismatch in the same CHECK cycle as an abort is still counted.
- rst_n low mid-run: immediate return to the reset values listed above.

Decomposition:
- Shared package and_mux_bist_pkg holds:
  - the state enum;
  - VEC_W = 3;
  - the golden function golden_y(vec) -> bit.
- One sub-module, bist_sat_counter (parameter W; ports clr, inc, count). It is used for err_count.

Test Plan:
- Defaults, y driven from an ideal golden model of the datapath → done at cycle 33 after start, err_count=0, pass=1, first_fail_valid=0.
- y stuck at 0 → err_count=3, first_fail_vec=3'b011, pass=0.
- y inverted, ERR_W=2 → err_count saturates at 3 (true count 8), first_fail_vec=3'b000.
- PASSES=2, y stuck at 1 → err_count=10 (5 per pass), done at cycle 65.
- Abort asserted 10 cycles after start → next cycle busy=0, dut_*=0, done=0. A second start then reaches done at cycle 33 with err_count=0.
- start pulsed while busy, and rst_n pulsed low mid-SETTLE → busy start ignored with no timing change; on reset all outputs return to 0 asynchronously.
